// File: rtl/modulo_r_counter.sv
// rtl/modulo_r_counter.sv - modulo-R up-counter with enable and terminal-count carry
// Optional synchronous clear port built when MODR_CLEAR_EN is defined.
module modulo_r_counter #(
    parameter int R     = 10,
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
`ifdef MODR_CLEAR_EN
    input  logic             clear,
`endif
    input  logic             enable,
    output logic [WIDTH-1:0] qout,
    output logic             cout
);

    localparam longint unsigned MAX_R = 64'd1 << WIDTH;
    localparam logic [WIDTH-1:0] TERM = WIDTH'(R - 1);

    if (R < 2 || longint'(R) > longint'(MAX_R)) begin : g_bad_r
        $error("modulo_r_counter: R=%0d outside 2..2**WIDTH", R);
    end

    logic             clear_w;
    logic [WIDTH-1:0] qout_q;
    logic [WIDTH-1:0] qout_d;

`ifdef MODR_CLEAR_EN
    assign clear_w = clear;
`else
    assign clear_w = 1'b0;
`endif

    // The >= test pulls any out-of-range value back to zero in one enabled cycle.
    always_comb begin
        qout_d = qout_q;
        if (clear_w) begin
            qout_d = '0;
        end else if (enable) begin
            if (qout_q >= TERM) begin
                qout_d = '0;
            end else begin
                qout_d = qout_q + WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            qout_q <= '0;
        end else begin
            qout_q <= qout_d;
        end
    end

    assign qout = qout_q;
    assign cout = reset & enable & ~clear_w & (qout_q == TERM);

endmodule

// File: tb/tb_modulo_r_counter.sv
// tb/tb_modulo_r_counter.sv - directed-vector bench for modulo_r_counter (R=10, WIDTH=4)
// Define MODR_CLEAR_EN to also exercise the clear port.
module tb_modulo_r_counter;

    logic       clk;
    logic       reset;
    logic       enable;
`ifdef MODR_CLEAR_EN
    logic       clear;
`endif
    logic [3:0] qout;
    logic       cout;

    int n_vec;
    int n_err;

    modulo_r_counter #(.R(10), .WIDTH(4)) dut (
        .clk    (clk),
        .reset  (reset),
`ifdef MODR_CLEAR_EN
        .clear  (clear),
`endif
        .enable (enable),
        .qout   (qout),
        .cout   (cout)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic test_reset;
        reset  = 1'b0;
        enable = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        n_vec++;
        if (qout !== 4'b0000 || cout !== 1'b0) begin
            n_err++;
            $display("FAIL reset_hold: qout=%b cout=%b expected qout=0000 cout=0", qout, cout);
        end
        // no count may occur on an edge while reset is still low
        enable = 1'b1;
        @(posedge clk);
        @(negedge clk);
        n_vec++;
        if (qout !== 4'b0000 || cout !== 1'b0) begin
            n_err++;
            $display("FAIL reset_blocks_count: qout=%b cout=%b expected qout=0000 cout=0", qout, cout);
        end
        reset = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        n_vec++;
        if (qout !== 4'b0010) begin
            n_err++;
            $display("FAIL reset_release_count: qout=%b expected 0010", qout);
        end
        #2 reset = 1'b0;
        #1;
        n_vec++;
        if (qout !== 4'b0000 || cout !== 1'b0) begin
            n_err++;
            $display("FAIL reset_async: qout=%b cout=%b expected qout=0000 cout=0", qout, cout);
        end
        enable = 1'b0;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_release_idle;
        reset  = 1'b1;
        enable = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            @(negedge clk);
            n_vec++;
            if (qout !== 4'b0000 || cout !== 1'b0) begin
                n_err++;
                $display("FAIL idle_after_release[%0d]: qout=%b cout=%b expected qout=0000 cout=0", i, qout, cout);
            end
        end
    endtask

    task automatic test_count_wrap;
        logic [3:0] exp_q;
        logic       exp_c;
        enable = 1'b1;
        #1;
        for (int i = 0; i < 15; i++) begin
            exp_q = 4'(i % 10);
            exp_c = (i % 10 == 9);
            n_vec++;
            if (qout !== exp_q || cout !== exp_c) begin
                n_err++;
                $display("FAIL count_wrap[%0d]: qout=%b cout=%b expected qout=%b cout=%b", i, qout, cout, exp_q, exp_c);
            end
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic test_enable_hold;
        enable = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            n_vec++;
            if (qout !== 4'b0101 || cout !== 1'b0) begin
                n_err++;
                $display("FAIL enable_hold[%0d]: qout=%b cout=%b expected qout=0101 cout=0", i, qout, cout);
            end
            @(posedge clk);
            @(negedge clk);
        end
        enable = 1'b1;
        @(posedge clk);
        @(negedge clk);
        n_vec++;
        if (qout !== 4'b0110) begin
            n_err++;
            $display("FAIL enable_resume: qout=%b expected 0110", qout);
        end
    endtask

    task automatic test_cout_gating;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
        end
        @(negedge clk);
        n_vec++;
        if (qout !== 4'b1001 || cout !== 1'b1) begin
            n_err++;
            $display("FAIL cout_at_term: qout=%b cout=%b expected qout=1001 cout=1", qout, cout);
        end
        enable = 1'b0;
        #1;
        n_vec++;
        if (cout !== 1'b0) begin
            n_err++;
            $display("FAIL cout_follows_enable_low: cout=%b expected 0", cout);
        end
        @(posedge clk);
        @(negedge clk);
        n_vec++;
        if (qout !== 4'b1001) begin
            n_err++;
            $display("FAIL no_wrap_when_disabled: qout=%b expected 1001", qout);
        end
        enable = 1'b1;
        #1;
        n_vec++;
        if (cout !== 1'b1) begin
            n_err++;
            $display("FAIL cout_follows_enable_high: cout=%b expected 1", cout);
        end
    endtask

    task automatic test_reset_midcount;
        #2 reset = 1'b0;
        #1;
        n_vec++;
        if (qout !== 4'b0000 || cout !== 1'b0) begin
            n_err++;
            $display("FAIL reset_midcount: qout=%b cout=%b expected qout=0000 cout=0", qout, cout);
        end
        @(posedge clk);
        @(negedge clk);
        n_vec++;
        if (qout !== 4'b0000 || cout !== 1'b0) begin
            n_err++;
            $display("FAIL reset_midcount_hold: qout=%b cout=%b expected qout=0000 cout=0", qout, cout);
        end
        reset = 1'b1;
    endtask

`ifdef MODR_CLEAR_EN
    task automatic test_clear;
        clear  = 1'b0;
        enable = 1'b1;
        for (int i = 0; i < 7; i++) begin
            @(posedge clk);
        end
        @(negedge clk);
        n_vec++;
        if (qout !== 4'b0111) begin
            n_err++;
            $display("FAIL clear_setup: qout=%b expected 0111", qout);
        end
        clear = 1'b1;
        @(posedge clk);
        @(negedge clk);
        n_vec++;
        if (qout !== 4'b0000 || cout !== 1'b0) begin
            n_err++;
            $display("FAIL clear_at_7: qout=%b cout=%b expected qout=0000 cout=0", qout, cout);
        end
        clear = 1'b0;
        for (int i = 0; i < 9; i++) begin
            @(posedge clk);
        end
        @(negedge clk);
        clear = 1'b1;
        #1;
        n_vec++;
        if (qout !== 4'b1001 || cout !== 1'b0) begin
            n_err++;
            $display("FAIL clear_masks_cout: qout=%b cout=%b expected qout=1001 cout=0", qout, cout);
        end
        @(posedge clk);
        @(negedge clk);
        n_vec++;
        if (qout !== 4'b0000) begin
            n_err++;
            $display("FAIL clear_at_9: qout=%b expected 0000", qout);
        end
        clear = 1'b0;
    endtask
`endif

    initial begin
        n_vec  = 0;
        n_err  = 0;
        reset  = 1'b0;
        enable = 1'b0;
`ifdef MODR_CLEAR_EN
        clear  = 1'b0;
`endif
        test_reset();
        test_release_idle();
        test_count_wrap();
        test_enable_hold();
        test_cout_gating();
        test_reset_midcount();
`ifdef MODR_CLEAR_EN
        test_clear();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
